// File: rtl/gf_koa_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gf_koa_pkg
// Purpose  : Shared types, constants and the modular fold helper for the
//            GF(2^N) Karatsuba merger datapath.
// Revision : 1.0 - initial release
// ============================================================================
package gf_koa_pkg;

    // Widest operand the fold helper supports; NB_DATA must not exceed it.
    localparam int MAX_NB_DATA = 128;

    // GCM field: x^128 + x^7 + x^2 + x + 1 (low-order part only).
    localparam logic [127:0] GCM_POLY_R = 128'h87;

    // Sub-field order inside one input channel slice, lo in the LSBs.
    localparam int LO_IDX        = 0;
    localparam int HI_IDX        = 1;
    localparam int MID_IDX       = 2;
    localparam int IN_SUBFIELDS  = 3;
    localparam int OUT_SUBFIELDS = 2;

    typedef enum logic {
        MODE_MERGE  = 1'b0,
        MODE_REDUCE = 1'b1
    } koa_mode_e;

    // MSB-first fold of a carry-less product modulo x^nb_data + r.
    // Each set bit i >= nb_data is cleared and replaced by r << (i - nb_data);
    // since deg(r) < nb_data that term never reaches bit i again.
    function automatic logic [MAX_NB_DATA-1:0] clmul_fold(
        input logic [2*MAX_NB_DATA-1:0] p,
        input logic [MAX_NB_DATA-1:0]   r,
        input int                       nb_data
    );
        logic [2*MAX_NB_DATA-1:0] acc;
        acc = p;
        for (int i = 2*MAX_NB_DATA-2; i >= 0; i--) begin
            if (i >= nb_data && i <= 2*nb_data-2 && acc[i]) begin
                acc[i] = 1'b0;
                acc    = acc ^ ({{MAX_NB_DATA{1'b0}}, r} << (i - nb_data));
            end
        end
        return acc[MAX_NB_DATA-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf_2ton_koa_merge_core.sv
`default_nettype none
// ============================================================================
// Module   : gf_2ton_koa_merge_core
// Purpose  : Combinational Karatsuba merge of three half-width carry-less
//            partial products into the full 2N-1 bit product.
// Revision : 1.0 - initial release
// ============================================================================
module gf_2ton_koa_merge_core #(
    parameter int NB_DATA = 128
) (
    input  logic [NB_DATA-1:0]   i_lo,
    input  logic [NB_DATA-1:0]   i_hi,
    input  logic [NB_DATA-1:0]   i_mid,
    output logic [2*NB_DATA-1:0] o_product
);

    localparam int H = NB_DATA / 2;

    logic [2*NB_DATA-1:0] w_lo_ext;
    logic [2*NB_DATA-1:0] w_hi_ext;
    logic [2*NB_DATA-1:0] w_mid_ext;
    logic                 w_msb_unused;

    // Partial products are only 2H-1 bits wide; the top sub-field bit is dropped.
    assign w_lo_ext  = {{(NB_DATA+1){1'b0}}, i_lo[NB_DATA-2:0]};
    assign w_hi_ext  = {{(NB_DATA+1){1'b0}}, i_hi[NB_DATA-2:0]};
    assign w_mid_ext = {{(NB_DATA+1){1'b0}}, i_mid[NB_DATA-2:0]};
    assign w_msb_unused = i_lo[NB_DATA-1] ^ i_hi[NB_DATA-1] ^ i_mid[NB_DATA-1];

    // P = hi*x^N + (mid ^ hi ^ lo)*x^H + lo; the top output bit stays 0.
    assign o_product = (w_hi_ext << NB_DATA)
                     ^ ((w_mid_ext ^ w_hi_ext ^ w_lo_ext) << H)
                     ^ w_lo_ext;

endmodule
`default_nettype wire

// File: rtl/gf_2ton_koa_merger_pipe.sv
`default_nettype none
// ============================================================================
// Module   : gf_2ton_koa_merger_pipe
// Purpose  : Multi-channel 2-stage Karatsuba merger with optional reduction
//            modulo x^NB_DATA + POLY_R, valid/ready handshake, flush and an
//            output beat counter.
// Revision : 1.0 - initial release
// ============================================================================
module gf_2ton_koa_merger_pipe
    import gf_koa_pkg::*;
#(
    parameter int                 N_CHANNELS = 3,
    parameter int                 NB_DATA    = 128,
    parameter int                 NB_TAG     = 8,
    parameter logic [NB_DATA-1:0] POLY_R     = GCM_POLY_R[NB_DATA-1:0]
) (
    input  logic                                i_clock,
    input  logic                                i_reset,
    input  logic [N_CHANNELS*3*NB_DATA-1:0]     i_data_bus,
    input  logic                                i_mode,
    input  logic [NB_TAG-1:0]                   i_tag,
    input  logic                                i_valid,
    output logic                                o_ready,
    output logic [N_CHANNELS*2*NB_DATA-1:0]     o_data_bus,
    output logic [NB_TAG-1:0]                   o_tag,
    output logic                                o_valid,
    input  logic                                i_ready,
    input  logic                                i_flush,
    output logic [15:0]                         o_beat_count
);

    localparam int NB_IN_CH  = IN_SUBFIELDS * NB_DATA;
    localparam int NB_OUT_CH = OUT_SUBFIELDS * NB_DATA;
    localparam int NB_OUT    = N_CHANNELS * NB_OUT_CH;

    logic              w_adv1;
    logic              w_adv2;
    logic [NB_OUT-1:0] w_merged;
    logic [NB_OUT-1:0] w_reduced;

    logic              r_s1_valid;
    koa_mode_e         r_s1_mode;
    logic [NB_TAG-1:0] r_s1_tag;
    logic [NB_OUT-1:0] r_s1_data;

    logic              r_s2_valid;
    logic [NB_TAG-1:0] r_s2_tag;
    logic [NB_OUT-1:0] r_s2_data;
    logic [15:0]       r_beat_count;

    // Ready ripples back combinationally from i_ready through both stages.
    assign w_adv2  = ~r_s2_valid | i_ready;
    assign w_adv1  = ~r_s1_valid | w_adv2;
    assign o_ready = w_adv1;

    for (genvar ch = 0; ch < N_CHANNELS; ch++) begin : g_ch
        localparam int IN_BASE  = ch * NB_IN_CH;
        localparam int OUT_BASE = ch * NB_OUT_CH;

        logic [2*MAX_NB_DATA-1:0] w_p_ext;
        logic [MAX_NB_DATA-1:0]   w_r_ext;
        logic [MAX_NB_DATA-1:0]   w_fold;
        logic [NB_OUT_CH-1:0]     w_result;

        gf_2ton_koa_merge_core #(
            .NB_DATA (NB_DATA)
        ) u_core (
            .i_lo      (i_data_bus[IN_BASE + LO_IDX*NB_DATA  +: NB_DATA]),
            .i_hi      (i_data_bus[IN_BASE + HI_IDX*NB_DATA  +: NB_DATA]),
            .i_mid     (i_data_bus[IN_BASE + MID_IDX*NB_DATA +: NB_DATA]),
            .o_product (w_merged[OUT_BASE +: NB_OUT_CH])
        );

        // Stage-2 datapath: fold modulo the field polynomial in reduce mode.
        always_comb begin
            w_p_ext = '0;
            w_p_ext[NB_OUT_CH-1:0] = r_s1_data[OUT_BASE +: NB_OUT_CH];
            w_r_ext = '0;
            w_r_ext[NB_DATA-1:0] = POLY_R;
            w_fold   = clmul_fold(w_p_ext, w_r_ext, NB_DATA);
            w_result = r_s1_data[OUT_BASE +: NB_OUT_CH];
            if (r_s1_mode == MODE_REDUCE) begin
                w_result = {{NB_DATA{1'b0}}, w_fold[NB_DATA-1:0]};
            end
        end

        assign w_reduced[OUT_BASE +: NB_OUT_CH] = w_result;
    end

    // Stage 1: capture merged products with mode and tag on advance.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= MODE_MERGE;
            r_s1_tag   <= '0;
            r_s1_data  <= '0;
        end else if (i_flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_mode <= koa_mode_e'(i_mode);
                r_s1_tag  <= i_tag;
                r_s1_data <= w_merged;
            end
        end
    end

    // Stage 2: capture the (optionally reduced) result; holds while stalled.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_s2_valid <= 1'b0;
            r_s2_tag   <= '0;
            r_s2_data  <= '0;
        end else if (i_flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_tag  <= r_s1_tag;
                r_s2_data <= w_reduced;
            end
        end
    end

    // Count beats taken by the consumer; flush leaves the count alone.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_beat_count <= '0;
        end else if (r_s2_valid && i_ready) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    assign o_valid      = r_s2_valid;
    assign o_tag        = r_s2_tag;
    assign o_data_bus   = r_s2_data;
    assign o_beat_count = r_beat_count;

endmodule
`default_nettype wire

// File: tb/tb_gf_2ton_koa_merger_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf_2ton_koa_merger_pipe
// Purpose  : Scoreboard bench for the Karatsuba merger: an 8-bit AES-field
//            instance for handshake/flush/reset cases and a 3-channel GCM
//            instance for random multi-channel traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf_2ton_koa_merger_pipe;

    localparam int GC = 3;
    localparam int GN = 128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 8-bit instance
    logic [23:0]  s_din;
    logic         s_mode, s_valid, s_ready, s_ovalid, s_iready, s_flush;
    logic [7:0]   s_tag, s_tag_out;
    logic [15:0]  s_dout, s_count;

    // GCM instance
    logic [GC*3*GN-1:0] g_din;
    logic [GC*2*GN-1:0] g_dout;
    logic               g_mode, g_valid, g_ready, g_ovalid, g_iready, g_flush;
    logic [7:0]         g_tag, g_tag_out;
    logic [15:0]        g_count;

    gf_2ton_koa_merger_pipe #(
        .N_CHANNELS (1), .NB_DATA (8), .NB_TAG (8), .POLY_R (8'h1B)
    ) u_dut_small (
        .i_clock (clk), .i_reset (rst), .i_data_bus (s_din), .i_mode (s_mode),
        .i_tag (s_tag), .i_valid (s_valid), .o_ready (s_ready),
        .o_data_bus (s_dout), .o_tag (s_tag_out), .o_valid (s_ovalid),
        .i_ready (s_iready), .i_flush (s_flush), .o_beat_count (s_count)
    );

    gf_2ton_koa_merger_pipe #(
        .N_CHANNELS (GC), .NB_DATA (GN), .NB_TAG (8), .POLY_R (128'h87)
    ) u_dut_gcm (
        .i_clock (clk), .i_reset (rst), .i_data_bus (g_din), .i_mode (g_mode),
        .i_tag (g_tag), .i_valid (g_valid), .o_ready (g_ready),
        .o_data_bus (g_dout), .o_tag (g_tag_out), .o_valid (g_ovalid),
        .i_ready (g_iready), .i_flush (g_flush), .o_beat_count (g_count)
    );

    int           n_vec = 0;
    int           n_bad = 0;
    logic [15:0]  s_exp;
    logic [767:0] g_exp;
    logic [23:0]  s_q[$];
    logic [775:0] g_q[$];
    logic [15:0]  s_beats, g_beats;
    bit           s_acc, g_acc, g_rand_ready;

    task automatic chk(input string name, input logic [767:0] obs, input logic [767:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic logic [255:0] tb_clmul(input logic [127:0] a, input logic [127:0] b);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 128; i++)
            if (b[i]) r = r ^ ({128'b0, a} << i);
        return r;
    endfunction

    function automatic logic [127:0] tb_mod(input logic [255:0] p_in, input logic [127:0] r, input int nb);
        logic [255:0] p;
        p = p_in;
        for (int i = 2*nb-1; i >= nb; i--)
            if (p[i]) begin
                p[i] = 1'b0;
                p = p ^ ({128'b0, r} << (i - nb));
            end
        return p[127:0];
    endfunction

    // Karatsuba partial product: sel 0 = lo, 1 = hi, 2 = mid.
    function automatic logic [127:0] pp(input logic [127:0] a, input logic [127:0] b, input int nb, input int sel);
        logic [127:0] mask, al, ah, bl, bh;
        logic [255:0] r;
        mask = (128'b1 << (nb/2)) - 128'b1;
        al = a & mask; ah = (a >> (nb/2)) & mask;
        bl = b & mask; bh = (b >> (nb/2)) & mask;
        if (sel == 0)      r = tb_clmul(al, bl);
        else if (sel == 1) r = tb_clmul(ah, bh);
        else               r = tb_clmul(al ^ ah, bl ^ bh);
        return r[127:0];
    endfunction

    // One clock: score outputs and accepts just before the edge, then step past it.
    task automatic cycle();
        logic [23:0]  se;
        logic [775:0] ge;
        @(negedge clk);
        s_acc = 1'b0;
        g_acc = 1'b0;
        if (s_ovalid && s_iready) begin
            if (s_q.size() == 0) chk("s_extra_beat", 1, 0);
            else begin
                se = s_q.pop_front();
                chk("s_data", s_dout, se[15:0]);
                chk("s_tag", s_tag_out, se[23:16]);
            end
            s_beats++;
        end
        if (s_flush) s_q.delete();
        else if (s_valid && s_ready) begin s_q.push_back({s_tag, s_exp}); s_acc = 1'b1; end
        if (g_ovalid && g_iready) begin
            if (g_q.size() == 0) chk("g_extra_beat", 1, 0);
            else begin
                ge = g_q.pop_front();
                chk("g_data", g_dout, ge[767:0]);
                chk("g_tag", g_tag_out, ge[775:768]);
            end
            g_beats++;
        end
        if (g_flush) g_q.delete();
        else if (g_valid && g_ready) begin g_q.push_back({g_tag, g_exp}); g_acc = 1'b1; end
        @(posedge clk);
        #1;
    endtask

    task automatic set_s_raw(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] mid,
                             input logic mode, input logic [7:0] tag, input logic [15:0] exp);
        s_din = {mid, hi, lo}; s_mode = mode; s_tag = tag; s_exp = exp;
    endtask

    task automatic set_s(input logic [7:0] a, input logic [7:0] b, input logic mode, input logic [7:0] tag);
        logic [255:0] full;
        logic [127:0] red, lo, hi, mid;
        full = tb_clmul({120'b0, a}, {120'b0, b});
        red  = tb_mod(full, 128'h1B, 8);
        lo = pp({120'b0, a}, {120'b0, b}, 8, 0);
        hi = pp({120'b0, a}, {120'b0, b}, 8, 1);
        mid = pp({120'b0, a}, {120'b0, b}, 8, 2);
        set_s_raw(lo[7:0], hi[7:0], mid[7:0], mode, tag, mode ? {8'h00, red[7:0]} : full[15:0]);
    endtask

    task automatic send_s();
        int n;
        s_valid = 1'b1;
        n = 0;
        do begin cycle(); n++; end while (!s_acc && n < 40);
        if (!s_acc) chk("s_send_timeout", 1, 0);
        s_valid = 1'b0;
    endtask

    task automatic send_g(input logic mode, input logic [7:0] tag);
        logic [127:0] a, b, red;
        logic [255:0] full;
        int n;
        for (int ch = 0; ch < GC; ch++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            full = tb_clmul(a, b);
            red  = tb_mod(full, 128'h87, 128);
            g_din[ch*384 +: 384] = {pp(a, b, 128, 2), pp(a, b, 128, 1), pp(a, b, 128, 0)};
            g_exp[ch*256 +: 256] = mode ? {128'b0, red} : full;
        end
        g_mode = mode; g_tag = tag; g_valid = 1'b1;
        n = 0;
        do begin
            if (g_rand_ready) g_iready = ($urandom_range(0, 3) != 0);
            cycle(); n++;
        end while (!g_acc && n < 40);
        if (!g_acc) chk("g_send_timeout", 1, 0);
        g_valid = 1'b0;
    endtask

    task automatic drain();
        s_iready = 1'b1; g_iready = 1'b1; g_rand_ready = 1'b0;
        for (int i = 0; i < 30 && (s_q.size() != 0 || g_q.size() != 0); i++) cycle();
        repeat (3) cycle();
        chk("s_drain_left", s_q.size(), 0);
        chk("g_drain_left", g_q.size(), 0);
        chk("s_count", s_count, s_beats);
        chk("g_count", g_count, g_beats);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held_d;
        logic [7:0]  held_t;
        int k;
        rst = 1'b1;
        s_din = '0; s_mode = 0; s_tag = '0; s_valid = 0; s_iready = 1; s_flush = 0;
        g_din = '0; g_mode = 0; g_tag = '0; g_valid = 0; g_iready = 1; g_flush = 0;
        s_exp = '0; g_exp = '0; s_beats = '0; g_beats = '0; g_rand_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_s_valid", s_ovalid, 0);
        chk("rst_s_data", s_dout, 0);
        chk("rst_s_tag", s_tag_out, 0);
        chk("rst_s_count", s_count, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_g_valid", g_ovalid, 0);
        chk("rst_g_data", g_dout, 0);
        chk("rst_g_ready", g_ready, 1);

        // Merge-only vector with 2-cycle latency
        set_s_raw(8'h09, 8'h28, 8'h16, 1'b0, 8'hA1, 16'h2B79);
        send_s();
        chk("s_lat1_valid", s_ovalid, 0);
        cycle();
        chk("s_lat2_valid", s_ovalid, 1);
        chk("s_merge_2b79", s_dout, 16'h2B79);
        drain();
        chk("s_count_one", s_count, 1);

        // Reduce vectors; ignored top bit set on lo for the first one
        set_s_raw(8'h89, 8'h28, 8'h16, 1'b1, 8'hA2, 16'h00C1); send_s();
        set_s_raw(8'h00, 8'h01, 8'h01, 1'b1, 8'hA3, 16'h001B); send_s();
        for (int i = 0; i < 6; i++) begin
            set_s(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), i[0], 8'(8'hB0 + i));
            send_s();
        end
        drain();

        // Backpressure: four beats against a stalled consumer
        s_iready = 1'b0; k = 0; held_d = '0; held_t = '0;
        for (int i = 0; i < 6; i++) begin
            if (k < 4) begin
                set_s(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), k[0], 8'(8'hC0 + k));
                s_valid = 1'b1;
            end
            cycle();
            if (s_acc) k++;
            if (i == 1) begin held_d = s_dout; held_t = s_tag_out; end
        end
        chk("bp_accepts", k, 2);
        chk("bp_ready_low", s_ready, 0);
        chk("bp_valid_held", s_ovalid, 1);
        chk("bp_data_held", s_dout, held_d);
        chk("bp_tag_held", s_tag_out, held_t);
        s_iready = 1'b1;
        for (int i = 0; i < 20 && k < 4; i++) begin
            set_s(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), k[0], 8'(8'hC0 + k));
            s_valid = 1'b1;
            cycle();
            if (s_acc) k++;
        end
        s_valid = 1'b0;
        chk("bp_all_accepted", k, 4);
        drain();

        // Flush with both stages full; the beat offered during flush is dropped
        s_iready = 1'b0;
        set_s(8'h12, 8'h34, 1'b0, 8'hD0); send_s();
        set_s(8'h56, 8'h78, 1'b1, 8'hD1); send_s();
        chk("fl_full_ready", s_ready, 0);
        set_s(8'h9A, 8'hBC, 1'b0, 8'hD2);
        s_flush = 1'b1; s_valid = 1'b1;
        cycle();
        s_flush = 1'b0; s_valid = 1'b0;
        chk("fl_valid", s_ovalid, 0);
        chk("fl_ready", s_ready, 1);
        chk("fl_count", s_count, s_beats);
        drain();

        // Asynchronous reset between edges while a beat is held at the output
        s_iready = 1'b0;
        set_s(8'hE1, 8'h5C, 1'b1, 8'hE0); send_s();
        cycle();
        chk("ar_pre_valid", s_ovalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_s_valid", s_ovalid, 0);
        chk("ar_s_data", s_dout, 0);
        chk("ar_s_count", s_count, 0);
        s_q.delete(); g_q.delete(); s_beats = '0; g_beats = '0;
        rst = 1'b0;
        s_iready = 1'b1;
        set_s_raw(8'h09, 8'h28, 8'h16, 1'b0, 8'hE1, 16'h2B79);
        send_s();
        chk("ar_lat1_valid", s_ovalid, 0);
        cycle();
        chk("ar_lat2_valid", s_ovalid, 1);
        drain();
        chk("ar_count_one", s_count, 1);

        // GCM multi-channel random traffic, alternating modes, random stalls
        g_rand_ready = 1'b1;
        for (int i = 0; i < 12; i++) send_g(i[0], 8'(8'h40 + i));
        drain();
        chk("g_count_final", g_count, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
